// File: rtl/pd_chunk_assembler_if.sv
// Bus between the packet-decoder front end and the chunk assembler: header word
// stream in, packed chunks plus hash sequencing status out.
interface pd_chunk_assembler_if #(parameter int WORD_W = 32);
    logic [WORD_W-1:0] word_in;
    logic              word_valid;
    logic              word_ready;
    logic              abort;
    logic              start;
    logic              chunk_done;
    logic              nonce_inc;
    logic              new_block;
    logic [511:0]      chunk1;
    logic [127:0]      chunk2;
    logic [1:0]        hash_select;
    logic              header_valid;
    logic              block_done;
    logic              nonce_wrap;

    modport master (
        output word_in, word_valid, abort, start, chunk_done, nonce_inc, new_block,
        input  word_ready, chunk1, chunk2, hash_select, header_valid, block_done, nonce_wrap
    );

    modport slave (
        input  word_in, word_valid, abort, start, chunk_done, nonce_inc, new_block,
        output word_ready, chunk1, chunk2, hash_select, header_valid, block_done, nonce_wrap
    );
endinterface

// File: rtl/pd_chunk_assembler.sv
// Packs a 640-bit block header from a word stream into chunk1/chunk2, sequences the
// two SHA-256 passes and bumps the nonce field between mining attempts.
module pd_chunk_assembler #(
    parameter int WORD_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    pd_chunk_assembler_if.slave  bus
);
    localparam int NWORDS = 640 / WORD_W;
    localparam int CW     = $clog2(NWORDS);

    typedef enum logic [1:0] {LOAD, READY, HASH1, HASH2} state_t;

    state_t          state;
    state_t          next_state;
    logic [CW-1:0]   count;
    logic [639:0]    header;
    logic            accept;
    logic            last_word;
    logic            nonce_step;
    logic            word_ready_d;
    logic            header_valid_d;
    logic            hash_select_d;
    logic            block_done_d;
    logic            nonce_wrap_d;

    assign accept     = (state == LOAD) && bus.word_valid && !bus.abort;
    assign last_word  = (count == CW'(NWORDS - 1));
    assign nonce_step = (state == READY) && bus.nonce_inc && !bus.abort;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= LOAD;
        else     state <= next_state;
    end

    // abort overrides everything; start/new_block/nonce_inc only matter in READY
    always_comb begin
        next_state = state;
        if (bus.abort) begin
            next_state = LOAD;
        end else begin
            case (state)
                LOAD:  if (bus.word_valid && last_word) next_state = READY;
                READY: begin
                    if (bus.new_block)  next_state = LOAD;
                    else if (bus.start) next_state = HASH1;
                end
                HASH1: if (bus.chunk_done) next_state = HASH2;
                HASH2: if (bus.chunk_done) next_state = READY;
                default: next_state = LOAD;
            endcase
        end
    end

    // Outputs are decoded from the next state so that they can be registered
    // and still line up with the state they describe.
    always_comb begin
        word_ready_d   = (next_state == LOAD);
        header_valid_d = (next_state != LOAD);
        hash_select_d  = (next_state == HASH2);
        block_done_d   = (state == HASH2) && (next_state == READY);
        nonce_wrap_d   = nonce_step && (header[31:0] == 32'hFFFF_FFFF);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count            <= '0;
            header           <= '0;
            bus.word_ready   <= 1'b1;
            bus.header_valid <= 1'b0;
            bus.hash_select  <= 2'd0;
            bus.block_done   <= 1'b0;
            bus.nonce_wrap   <= 1'b0;
        end else begin
            bus.word_ready   <= word_ready_d;
            bus.header_valid <= header_valid_d;
            bus.hash_select  <= {1'b0, hash_select_d};
            bus.block_done   <= block_done_d;
            bus.nonce_wrap   <= nonce_wrap_d;
            if (bus.abort) begin
                count <= '0;
            end else if (accept) begin
                count <= last_word ? '0 : count + 1'b1;
            end
            // first word lands in the most significant bits of the header
            if (accept) begin
                header[639 - int'(count) * WORD_W -: WORD_W] <= bus.word_in;
            end else if (nonce_step) begin
                header[31:0] <= header[31:0] + 32'd1;
            end
        end
    end

    assign bus.chunk1 = header[639:128];
    assign bus.chunk2 = header[127:0];
endmodule

// File: tb/tb_pd_chunk_assembler.sv
// Directed bench for pd_chunk_assembler: header loading, hash sequencing,
// nonce increment/wrap and abort, with hand-computed expectations.
module tb_pd_chunk_assembler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    pd_chunk_assembler_if #(.WORD_W(32)) bus ();

    pd_chunk_assembler #(.WORD_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        wv;
        logic [31:0] wi;
        logic        ab;
        logic        st;
        logic        cd;
        logic        ni;
        logic        nb;
        logic        exp_wr;
        logic        exp_hv;
        logic [1:0]  exp_hs;
        logic        exp_bd;
        logic        exp_nw;
        logic [31:0] exp_nonce;
    } vec_t;

    vec_t vecs[11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idleInputs();
        bus.word_valid = 1'b0;
        bus.word_in    = '0;
        bus.abort      = 1'b0;
        bus.start      = 1'b0;
        bus.chunk_done = 1'b0;
        bus.nonce_inc  = 1'b0;
        bus.new_block  = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        bus.word_valid = v.wv;
        bus.word_in    = v.wi;
        bus.abort      = v.ab;
        bus.start      = v.st;
        bus.chunk_done = v.cd;
        bus.nonce_inc  = v.ni;
        bus.new_block  = v.nb;
        tick();
        idleInputs();
        checkOutput({v.name, ".word_ready"},   128'(bus.word_ready),   128'(v.exp_wr));
        checkOutput({v.name, ".header_valid"}, 128'(bus.header_valid), 128'(v.exp_hv));
        checkOutput({v.name, ".hash_select"},  128'(bus.hash_select),  128'(v.exp_hs));
        checkOutput({v.name, ".block_done"},   128'(bus.block_done),   128'(v.exp_bd));
        checkOutput({v.name, ".nonce_wrap"},   128'(bus.nonce_wrap),   128'(v.exp_nw));
        checkOutput({v.name, ".nonce"},        128'(bus.chunk2[31:0]), 128'(v.exp_nonce));
    endtask

    // Words 1..19 then 'last'; gap inserts two idle cycles before each word.
    task automatic loadHeader(input bit gap, input logic [31:0] last);
        for (int i = 0; i < 20; i++) begin
            if (gap) begin
                idleInputs();
                tick();
                tick();
            end
            bus.word_valid = 1'b1;
            bus.word_in    = (i == 19) ? last : 32'(i + 1);
            tick();
            if (i == 18) checkOutput("hv_before_last", 128'(bus.header_valid), 128'd0);
        end
        idleInputs();
        checkOutput("hv_after_last", 128'(bus.header_valid), 128'd1);
        checkOutput("wr_after_last", 128'(bus.word_ready), 128'd0);
    endtask

    task automatic checkChunks(input string tag);
        checkOutput({tag, ".c1_hi"},  bus.chunk1[511:384], 128'h00000001_00000002_00000003_00000004);
        checkOutput({tag, ".c1_mh"},  bus.chunk1[383:256], 128'h00000005_00000006_00000007_00000008);
        checkOutput({tag, ".c1_ml"},  bus.chunk1[255:128], 128'h00000009_0000000a_0000000b_0000000c);
        checkOutput({tag, ".c1_lo"},  bus.chunk1[127:0],   128'h0000000d_0000000e_0000000f_00000010);
        checkOutput({tag, ".chunk2"}, bus.chunk2,          128'h00000011_00000012_00000013_00000014);
    endtask

    initial begin
        //             name         wv  wi            ab  st  cd  ni  nb  wr  hv  hs  bd  nw  nonce
        vecs[0]  = '{"start",      0, 32'h0,        0,  1,  0,  0,  0,  0,  1,  0,  0,  0,  32'h14};
        vecs[1]  = '{"hash1_hold", 0, 32'h0,        0,  0,  0,  0,  0,  0,  1,  0,  0,  0,  32'h14};
        vecs[2]  = '{"to_hash2",   0, 32'h0,        0,  0,  1,  0,  0,  0,  1,  1,  0,  0,  32'h14};
        vecs[3]  = '{"hash2_ign",  0, 32'h0,        0,  1,  0,  1,  1,  0,  1,  1,  0,  0,  32'h14};
        vecs[4]  = '{"to_ready",   0, 32'h0,        0,  0,  1,  0,  0,  0,  1,  0,  1,  0,  32'h14};
        vecs[5]  = '{"ready_word", 1, 32'hDEAD,     0,  0,  0,  0,  0,  0,  1,  0,  0,  0,  32'h14};
        vecs[6]  = '{"nonce_inc",  0, 32'h0,        0,  0,  0,  1,  0,  0,  1,  0,  0,  0,  32'h15};
        vecs[7]  = '{"inc_start",  0, 32'h0,        0,  1,  0,  1,  0,  0,  1,  0,  0,  0,  32'h16};
        vecs[8]  = '{"to_hash2b",  0, 32'h0,        0,  0,  1,  0,  0,  0,  1,  1,  0,  0,  32'h16};
        vecs[9]  = '{"abort_cd",   0, 32'h0,        1,  0,  1,  0,  0,  1,  0,  0,  0,  0,  32'h16};
        vecs[10] = '{"after_abt",  0, 32'h0,        0,  0,  0,  0,  0,  1,  0,  0,  0,  0,  32'h16};

        idleInputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst.word_ready",   128'(bus.word_ready),   128'd1);
        checkOutput("rst.header_valid", 128'(bus.header_valid), 128'd0);
        checkOutput("rst.hash_select",  128'(bus.hash_select),  128'd0);
        checkOutput("rst.block_done",   128'(bus.block_done),   128'd0);
        checkOutput("rst.nonce_wrap",   128'(bus.nonce_wrap),   128'd0);
        checkOutput("rst.chunk2",       bus.chunk2,             128'd0);
        @(negedge clk);
        rst = 1'b0;

        // reset in the middle of a header load
        for (int i = 0; i < 7; i++) begin
            bus.word_valid = 1'b1;
            bus.word_in    = 32'hA0 + 32'(i);
            tick();
        end
        idleInputs();
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midrst.chunk1_hi",   bus.chunk1[511:384],    128'd0);
        checkOutput("midrst.word_ready",  128'(bus.word_ready),   128'd1);
        checkOutput("midrst.header_valid",128'(bus.header_valid), 128'd0);
        @(negedge clk);
        rst = 1'b0;

        loadHeader(1'b0, 32'h14);
        checkChunks("b2b");

        for (int i = 0; i < 11; i++) applyStimulus(vecs[i]);

        // gapped load must give the same chunks; extra word in READY is dropped
        loadHeader(1'b1, 32'h14);
        checkChunks("gap");
        bus.word_valid = 1'b1;
        bus.word_in    = 32'hBEEF;
        tick();
        idleInputs();
        checkOutput("extra.word_ready", 128'(bus.word_ready), 128'd0);
        checkChunks("extra");

        // nonce wrap
        bus.new_block = 1'b1;
        tick();
        idleInputs();
        checkOutput("newblk.word_ready", 128'(bus.word_ready), 128'd1);
        loadHeader(1'b0, 32'hFFFF_FFFF);
        bus.nonce_inc = 1'b1;
        tick();
        idleInputs();
        checkOutput("wrap.nonce",      128'(bus.chunk2[31:0]),  128'd0);
        checkOutput("wrap.pulse",      128'(bus.nonce_wrap),    128'd1);
        checkOutput("wrap.upper",      128'(bus.chunk2[63:32]), 128'h13);
        tick();
        checkOutput("wrap.pulse_end",  128'(bus.nonce_wrap),    128'd0);

        // nonce_inc together with start from 0x5
        bus.new_block = 1'b1;
        tick();
        idleInputs();
        loadHeader(1'b0, 32'h5);
        bus.nonce_inc = 1'b1;
        bus.start     = 1'b1;
        tick();
        idleInputs();
        checkOutput("incst.nonce",        128'(bus.chunk2[31:0]), 128'h6);
        checkOutput("incst.hash_select",  128'(bus.hash_select),  128'd0);
        checkOutput("incst.header_valid", 128'(bus.header_valid), 128'd1);
        bus.chunk_done = 1'b1;
        tick();
        checkOutput("incst.hash2",        128'(bus.hash_select),  128'd1);
        tick();
        idleInputs();
        checkOutput("incst.block_done",   128'(bus.block_done),   128'd1);
        checkOutput("incst.back_ready",   128'(bus.hash_select),  128'd0);
        tick();
        checkOutput("incst.bd_end",       128'(bus.block_done),   128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
